wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Write-back side of the 32x32 register file. It merges single-cycle ALU results and variable-latency load/multiply (LSU) results onto the single register-file write port. A per-register busy scoreboard stalls issue while a long-latency result is outstanding. Sits between the execute/memory units and the register file's reg_write / rd / write_data_reg_file inputs.

Parameters:
XLEN, 32, data width of results and write port
NREG, 32, architectural registers; rd/rs fields are log2(NREG)=5 bits
FIFO_DEPTH, 2, LSU result buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
Instruction  in  32  instruction in decode; rs1=[19:15], rs2=[24:20], rd=[11:7]
alu_valid  in  1  ALU result present this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
lsu_issue  in  1  long-latency op issued this cycle; marks lsu_issue_rd busy
lsu_issue_rd  in  5  destination of issued long-latency op
lsu_valid  in  1  LSU result offered
lsu_ready  out  1  FIFO can accept; transfer when lsu_valid && lsu_ready
lsu_rd  in  5  LSU result destination
lsu_data  in  XLEN  LSU result
stall  out  1  decode must hold Instruction and not issue
reg_write  out  1  register-file write enable (registered)
rd_out  out  5  register-file write address (registered)
write_data_reg_file  out  XLEN  register-file write data (registered)

Behaviour:
- Reset (rst_n=0, async): reg_write=0, rd_out=0, write_data_reg_file=0, FIFO empty (count=0, pointers 0), busy[31:0]=0; hence stall=0, lsu_ready=1. Takes effect mid-operation; buffered results are discarded.
- LSU accept: lsu_ready = (count < FIFO_DEPTH). On transfer with lsu_rd!=0, push {rd,data}. Transfers with lsu_rd==0 are accepted and dropped.
- Port arbitration, per cycle: if alu_valid && alu_rd!=0, ALU wins; else if FIFO non-empty, pop head. The selected result appears on reg_write/rd_out/write_data_reg_file on the next rising edge (1-cycle latency). If nothing is selected, reg_write=0 and rd_out/data hold their previous values.
- ALU writes to x0 are never issued and leave the port free for the FIFO in that cycle.
- Simultaneous push and pop: both occur and count is unchanged. A push into a full FIFO cannot happen (lsu_ready=0). A push into an empty FIFO is not popped in the same cycle; minimum LSU latency is 2 edges.
- Scoreboard: busy[lsu_issue_rd] is set on lsu_issue (ignored when rd==0). busy[rd] is cleared on the edge where an LSU entry for rd is popped. If set and clear target the same register in one cycle, set wins. busy[0] is always 0.
- stall = busy[rs1] | busy[rs2] | busy[rd] | (count==FIFO_DEPTH). The full term guarantees ALU idles, so the FIFO drains and starvation is bounded. stall is combinational from state and Instruction.
- Ordering: WAW and RAW on a busy register are prevented by stall. Results for different registers may retire out of order.

Optional Feature:
WB_BYPASS_EN. When defined, adds outputs fwd_rs1_valid, fwd_rs1_data, fwd_rs2_valid, fwd_rs2_data (1/XLEN each). They are asserted when reg_write=1 and rd_out matches the rs1/rs2 field of Instruction (rd_out!=0), carrying write_data_reg_file, so decode can bypass the register file's same-edge write. When not defined, these ports are absent and there is no bypass logic.

Decomposition:
- Shared package riscv_pkg: XLEN, NREG, REG_ADDR_W=5, field-position constants (RS1_LSB=15, RS2_LSB=20, RD_LSB=7), typedef wb_entry_t {rd[4:0], data[XLEN-1:0]}.
- One sub-module: wb_fifo, a parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/count, async active-low reset.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> reg_write=0, rd_out=0, data=0, stall=0, lsu_ready=1. Release -> no write until a valid result arrives.
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF -> next edge reg_write=1, rd_out=5, data=0xDEADBEEF. ALU rd=0 -> reg_write=0.
- Scoreboard: lsu_issue rd=7; Instruction add x1,x7,x2 -> stall=1. LSU returns rd=7, data=0x1234 -> written 2 edges after transfer, busy[7] clears, stall falls.
- Contention: ALU valid with rd=3 for 3 consecutive cycles while LSU pushes rd=9 then rd=10 -> FIFO full, lsu_ready=0, stall=1. When ALU idles, rd=9 then rd=10 retire on successive cycles.
- Simultaneous set/clear: pop for rd=4 on the same cycle as lsu_issue rd=4 -> busy[4] stays 1.
- Reset mid-operation: FIFO holds 2 entries and busy[7]=1; pulse rst_n low -> FIFO empty, busy=0, no writes after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the write-back path: architectural sizes, instruction
// field positions and the buffered result entry.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

  function automatic reg_addr_t reg_field(input logic [31:0] instr, input int lsb);
    return instr[lsb +: REG_ADDR_W];
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between execute/memory units, decode and the register-file write port.
// Optional macro WB_BYPASS_EN adds the decode forwarding signals.
interface wb_arbiter_if;
  import riscv_pkg::*;

  logic [31:0]     instruction;
  logic            alu_valid;
  reg_addr_t       alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_issue;
  reg_addr_t       lsu_issue_rd;
  logic            lsu_valid;
  logic            lsu_ready;
  reg_addr_t       lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            stall;
  logic            reg_write;
  reg_addr_t       rd_out;
  logic [XLEN-1:0] write_data_reg_file;

`ifdef WB_BYPASS_EN
  logic            fwd_rs1_valid;
  logic [XLEN-1:0] fwd_rs1_data;
  logic            fwd_rs2_valid;
  logic [XLEN-1:0] fwd_rs2_data;

  modport master (
    output instruction, alu_valid, alu_rd, alu_data, lsu_issue, lsu_issue_rd,
           lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready, stall, reg_write, rd_out, write_data_reg_file,
           fwd_rs1_valid, fwd_rs1_data, fwd_rs2_valid, fwd_rs2_data
  );

  modport slave (
    input  instruction, alu_valid, alu_rd, alu_data, lsu_issue, lsu_issue_rd,
           lsu_valid, lsu_rd, lsu_data,
    output lsu_ready, stall, reg_write, rd_out, write_data_reg_file,
           fwd_rs1_valid, fwd_rs1_data, fwd_rs2_valid, fwd_rs2_data
  );
`else
  modport master (
    output instruction, alu_valid, alu_rd, alu_data, lsu_issue, lsu_issue_rd,
           lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready, stall, reg_write, rd_out, write_data_reg_file
  );

  modport slave (
    input  instruction, alu_valid, alu_rd, alu_data, lsu_issue, lsu_issue_rd,
           lsu_valid, lsu_rd, lsu_data,
    output lsu_ready, stall, reg_write, rd_out, write_data_reg_file
  );
`endif

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering long-latency results until the write port is free.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_entry_t        push_data_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and buffered LSU results onto the single register-file write port
// and stalls decode on busy registers. Optional macro WB_BYPASS_EN adds forwarding.
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  reg_addr_t        rs1, rs2, rd_dec;
  wb_entry_t        push_entry, head_entry;
  logic             push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  wb_src_e          src;

  logic [NREG-1:0]  busy_q, busy_d;
  logic             reg_write_q, reg_write_d;
  reg_addr_t        rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             unused_instr_bits;

  assign rs1    = reg_field(bus.instruction, RS1_LSB);
  assign rs2    = reg_field(bus.instruction, RS2_LSB);
  assign rd_dec = reg_field(bus.instruction, RD_LSB);
  assign unused_instr_bits = ^{bus.instruction[31:25], bus.instruction[14:12],
                               bus.instruction[6:0]};

  // Results for x0 are acknowledged but never buffered.
  assign bus.lsu_ready = ~fifo_full;
  assign push          = bus.lsu_valid & ~fifo_full & (bus.lsu_rd != '0);
  assign push_entry    = '{rd: bus.lsu_rd, data: bus.lsu_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    src = SRC_NONE;
    if (bus.alu_valid && (bus.alu_rd != '0)) src = SRC_ALU;
    else if (!fifo_empty)                    src = SRC_LSU;
  end

  assign pop = (src == SRC_LSU);

  always_comb begin
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    data_d      = data_q;
    case (src)
      SRC_ALU: begin
        reg_write_d = 1'b1;
        rd_d        = bus.alu_rd;
        data_d      = bus.alu_data;
      end
      SRC_LSU: begin
        reg_write_d = 1'b1;
        rd_d        = head_entry.rd;
        data_d      = head_entry.data;
      end
      default: ;
    endcase
  end

  // Set is applied after clear so a same-cycle re-issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_entry.rd] = 1'b0;
    if (bus.lsu_issue && (bus.lsu_issue_rd != '0)) busy_d[bus.lsu_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      busy_q      <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
    end
  end

  // A full buffer also stalls so the ALU goes idle and the buffer drains.
  assign bus.stall = busy_q[rs1] | busy_q[rs2] | busy_q[rd_dec] |
                     (fifo_count == CNT_W'(FIFO_DEPTH));

  assign bus.reg_write           = reg_write_q;
  assign bus.rd_out              = rd_q;
  assign bus.write_data_reg_file = data_q;

`ifdef WB_BYPASS_EN
  assign bus.fwd_rs1_valid = reg_write_q & (rd_q != '0) & (rd_q == rs1);
  assign bus.fwd_rs1_data  = data_q;
  assign bus.fwd_rs2_valid = reg_write_q & (rd_q != '0) & (rd_q == rs2);
  assign bus.fwd_rs2_data  = data_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: pending results as a queue, busy flags as a bit array.
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  bit          busy_m[32];
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  typedef struct {
    logic [31:0] instr;
    bit av; logic [4:0] ard; logic [31:0] adat;
    bit iss; logic [4:0] ird;
    bit lv; logic [4:0] lrd; logic [31:0] ldat;
    bit e_stall; bit e_ready; bit e_we; logic [4:0] e_rd; logic [31:0] e_data;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [31:0] mk(input int rs1, input int rs2, input int rd);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
  endfunction

  function automatic vec_t v(input logic [31:0] instr, input bit av, input int ard,
                             input logic [31:0] adat, input bit iss, input int ird,
                             input bit lv, input int lrd, input logic [31:0] ldat,
                             input bit es, input bit er, input bit ew, input int erd,
                             input logic [31:0] edat);
    vec_t r;
    r.instr = instr; r.av = av; r.ard = 5'(ard); r.adat = adat;
    r.iss = iss; r.ird = 5'(ird); r.lv = lv; r.lrd = 5'(lrd); r.ldat = ldat;
    r.e_stall = es; r.e_ready = er; r.e_we = ew; r.e_rd = 5'(erd); r.e_data = edat;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model_reset();
    mq.delete();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    m_we = 1'b0; m_rd = '0; m_data = '0;
  endfunction

  function automatic bit model_stall();
    int rs1, rs2, rd;
    rs1 = int'((bus.instruction >> 15) & 32'd31);
    rs2 = int'((bus.instruction >> 20) & 32'd31);
    rd  = int'((bus.instruction >> 7) & 32'd31);
    return busy_m[rs1] | busy_m[rs2] | busy_m[rd] | (mq.size() == DEPTH);
  endfunction

  function automatic void model_clock();
    ent_t h;
    int   sz;
    bit   accept;
    sz     = mq.size();
    accept = bus.lsu_valid && (sz < DEPTH);
    m_we   = 1'b0;
    if (bus.alu_valid && bus.alu_rd != 0) begin
      m_we = 1'b1; m_rd = bus.alu_rd; m_data = bus.alu_data;
    end else if (sz > 0) begin
      h = mq.pop_front();
      m_we = 1'b1; m_rd = h.rd; m_data = h.data;
      busy_m[h.rd] = 1'b0;
    end
    if (accept && bus.lsu_rd != 0) mq.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
    if (bus.lsu_issue && bus.lsu_issue_rd != 0) busy_m[bus.lsu_issue_rd] = 1'b1;
  endfunction

  task automatic drive(input logic [31:0] instr, input bit av, input int ard,
                       input logic [31:0] adat, input bit iss, input int ird,
                       input bit lv, input int lrd, input logic [31:0] ldat);
    bus.instruction  = instr;
    bus.alu_valid    = av;   bus.alu_rd   = 5'(ard); bus.alu_data = adat;
    bus.lsu_issue    = iss;  bus.lsu_issue_rd = 5'(ird);
    bus.lsu_valid    = lv;   bus.lsu_rd   = 5'(lrd); bus.lsu_data = ldat;
  endtask

  task automatic idle(input logic [31:0] instr);
    drive(instr, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_inputs();
    drive(mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
          ($urandom_range(0, 1) == 1), $urandom_range(0, 7), $urandom,
          ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
          ($urandom_range(0, 1) == 1), $urandom_range(0, 7), $urandom);
  endtask

  // Entered at a falling edge with inputs set; returns at the next falling edge.
  task automatic step_model(input string tag);
    #1;
    chk({tag, ".stall"}, 32'(bus.stall), 32'(model_stall()));
    chk({tag, ".ready"}, 32'(bus.lsu_ready), 32'(mq.size() < DEPTH));
    @(posedge clk);
    model_clock();
    #1;
    chk({tag, ".we"},   32'(bus.reg_write), 32'(m_we));
    chk({tag, ".rd"},   32'(bus.rd_out), 32'(m_rd));
    chk({tag, ".data"}, bus.write_data_reg_file, m_data);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".we"},    32'(bus.reg_write), 32'd0);
    chk({tag, ".rd"},    32'(bus.rd_out), 32'd0);
    chk({tag, ".data"},  bus.write_data_reg_file, 32'd0);
    chk({tag, ".stall"}, 32'(bus.stall), 32'd0);
    chk({tag, ".ready"}, 32'(bus.lsu_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] nop, i17;
    nop = mk(0, 0, 0);
    i17 = mk(7, 2, 1);

    //        instr av rd adat          is rd lv rd ldat          st rdy we rd edat
    tbl[0]  = v(nop, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0);
    tbl[1]  = v(nop, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        0, 1, 1, 5, 32'hDEADBEEF);
    tbl[2]  = v(nop, 1, 0, 32'h11111111, 0, 0, 0, 0, 32'h0,        0, 1, 0, 5, 32'hDEADBEEF);
    tbl[3]  = v(nop, 0, 0, 32'h0,        1, 7, 0, 0, 32'h0,        0, 1, 0, 5, 32'hDEADBEEF);
    tbl[4]  = v(i17, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 1, 0, 5, 32'hDEADBEEF);
    tbl[5]  = v(i17, 0, 0, 32'h0,        0, 0, 1, 7, 32'h1234,     1, 1, 0, 5, 32'hDEADBEEF);
    tbl[6]  = v(i17, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 1, 1, 7, 32'h1234);
    tbl[7]  = v(i17, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 0, 7, 32'h1234);
    tbl[8]  = v(nop, 1, 3, 32'hA0,       0, 0, 1, 9, 32'h99,       0, 1, 1, 3, 32'hA0);
    tbl[9]  = v(nop, 1, 3, 32'hA1,       0, 0, 1, 10, 32'hAA,      0, 1, 1, 3, 32'hA1);
    tbl[10] = v(nop, 1, 3, 32'hA2,       0, 0, 1, 11, 32'hBB,      1, 0, 1, 3, 32'hA2);
    tbl[11] = v(nop, 0, 0, 32'h0,        0, 0, 1, 11, 32'hBB,      1, 0, 1, 9, 32'h99);
    tbl[12] = v(nop, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 1, 10, 32'hAA);
    tbl[13] = v(nop, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 0, 10, 32'hAA);
    tbl[14] = v(nop, 0, 0, 32'h0,        0, 0, 1, 0, 32'h55,       0, 1, 0, 10, 32'hAA);
    tbl[15] = v(nop, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 0, 10, 32'hAA);

    // Reset held with random inputs across several edges.
    rst_n = 1'b0;
    rand_inputs();
    @(posedge clk);
    rand_inputs();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    model_reset();
    @(negedge clk);
    idle(nop);
    rst_n = 1'b1;
    step_model("post_reset0");
    step_model("post_reset1");

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].instr, tbl[i].av, int'(tbl[i].ard), tbl[i].adat, tbl[i].iss,
            int'(tbl[i].ird), tbl[i].lv, int'(tbl[i].lrd), tbl[i].ldat);
      #1;
      chk($sformatf("vec%0d.stall", i), 32'(bus.stall), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d.ready", i), 32'(bus.lsu_ready), 32'(tbl[i].e_ready));
      @(posedge clk);
      model_clock();
      #1;
      chk($sformatf("vec%0d.we", i),   32'(bus.reg_write), 32'(tbl[i].e_we));
      chk($sformatf("vec%0d.rd", i),   32'(bus.rd_out), 32'(tbl[i].e_rd));
      chk($sformatf("vec%0d.data", i), bus.write_data_reg_file, tbl[i].e_data);
      @(negedge clk);
    end

    // Pop of x4 coincides with a fresh issue to x4: register stays busy.
    drive(nop, 0, 0, 0, 1, 4, 0, 0, 0);
    step_model("setclr.issue");
    drive(nop, 0, 0, 0, 0, 0, 1, 4, 32'h44);
    step_model("setclr.push");
    drive(nop, 0, 0, 0, 1, 4, 0, 0, 0);
    step_model("setclr.pop");
    chk("setclr.pop_rd", 32'(bus.rd_out), 32'd4);
    idle(mk(0, 0, 4));
    #1;
    chk("setclr.busy4", 32'(bus.stall), 32'd1);
    step_model("setclr.after");

    // Reset in the middle of operation: two buffered entries and busy x7.
    drive(nop, 1, 3, 32'h1, 1, 7, 1, 12, 32'hC);
    step_model("midrst.fill0");
    drive(nop, 1, 3, 32'h2, 0, 0, 1, 13, 32'hD);
    step_model("midrst.fill1");
    drive(mk(7, 0, 0), 1, 3, 32'h3, 0, 0, 0, 0, 0);
    #1;
    chk("midrst.full_stall", 32'(bus.stall), 32'd1);
    chk("midrst.full_ready", 32'(bus.lsu_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(mk(7, 0, 0));
    for (int i = 0; i < 3; i++) step_model($sformatf("midrst.after%0d", i));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
